// File: rtl/cache_control.sv
// cache_control: direct-mapped L1 cache controller with write-back/allocate miss handling
module cache_control #(
   parameter int TAG_W  = 8,
   parameter int IDX_W  = 3,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [15:0]       mem_address,
   input  logic [1:0]        mem_byte_enable,
   input  logic [15:0]       mem_wdata,
   output logic [15:0]       mem_rdata,
   output logic              mem_resp,
   output logic              array_write,
   output logic [IDX_W-1:0]  array_index,
   output logic [LINE_W-1:0] array_datain,
   input  logic [LINE_W-1:0] array_dataout,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [15:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   localparam int LINES = 2**IDX_W;
   localparam int OFF_W = 16 - TAG_W - IDX_W;
   typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;
   state_t              r_state;
   logic [LINES-1:0]    r_valid;
   logic [LINES-1:0]    r_dirty;
   logic [TAG_W-1:0]    r_tag [LINES];
   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [OFF_W-2:0]    w_word;
   logic [OFF_W+2:0]    w_bit;
   logic                w_req;
   logic                w_hit;
   logic [15:0]         w_old_word;
   logic [15:0]         w_new_word;
   logic [LINE_W-1:0]   w_merged;
   logic                w_unused;
   assign w_idx      = mem_address[OFF_W+IDX_W-1:OFF_W];
   assign w_tag      = mem_address[15:16-TAG_W];
   assign w_word     = mem_address[OFF_W-1:1];
   assign w_bit      = {w_word, 4'b0000};
   assign w_unused   = mem_address[0];
   assign w_req      = mem_read | mem_write;
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_old_word = array_dataout[w_bit +: 16];
   assign w_new_word = {mem_byte_enable[1] ? mem_wdata[15:8] : w_old_word[15:8],
                        mem_byte_enable[0] ? mem_wdata[7:0]  : w_old_word[7:0]};
   // store hit: splice the byte-merged word back into the current line
   always_comb begin
      w_merged = array_dataout;
      w_merged[w_bit +: 16] = w_new_word;
   end
   assign array_index  = w_idx;
   assign mem_resp     = (r_state == CHECK) && w_req && w_hit;
   assign mem_rdata    = (mem_resp && !mem_write) ? w_old_word : '0;
   assign array_write  = (mem_resp && mem_write) || ((r_state == ALLOCATE) && pmem_resp);
   assign array_datain = (r_state == ALLOCATE) ? pmem_rdata : w_merged;
   assign pmem_write   = r_state == WRITEBACK;
   assign pmem_read    = r_state == ALLOCATE;
   assign pmem_wdata   = array_dataout;
   assign pmem_address = pmem_write ? {r_tag[w_idx], w_idx, {OFF_W{1'b0}}} :
                         pmem_read  ? {mem_address[15:OFF_W], {OFF_W{1'b0}}} : '0;
   // controller state and per-line tag/valid/dirty bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_valid <= '0;
         r_dirty <= '0;
         for (int i = 0; i < LINES; i++) r_tag[i] <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_req) r_state <= CHECK;
            CHECK: begin
               if (!w_req || w_hit) r_state <= IDLE;
               else r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
               if (mem_resp && mem_write) r_dirty[w_idx] <= 1'b1;
            end
            WRITEBACK: if (pmem_resp) r_state <= ALLOCATE;
            ALLOCATE: if (pmem_resp) begin
               r_state        <= CHECK;
               r_valid[w_idx] <= 1'b1;
               r_dirty[w_idx] <= 1'b0;
               r_tag[w_idx]   <= w_tag;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
